// File: rtl/ifmap_window_gen_pkg.sv
// Shared definitions for the 3x3 input-feature-map window generator:
// FSM encoding, window geometry and the window packing index.
package ifmap_window_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_state_t;

  localparam int unsigned WIN_PIX    = 9;
  localparam int unsigned PIX_W_DFLT = 8;
  localparam int unsigned WIN_W      = WIN_PIX * PIX_W_DFLT;

  // MSB of window element (r, c); element 0 (top-left) sits in the top byte.
  function automatic int unsigned win_msb(input int unsigned r,
                                          input int unsigned c,
                                          input int unsigned pix_w);
    return WIN_PIX * pix_w - 1 - pix_w * (3 * r + c);
  endfunction

endpackage

// File: rtl/ifmap_window_gen_linebuf.sv
// One image row of delay: an enable-gated shift register whose output is
// the pixel written DEPTH accepted pixels earlier (same column, previous row).
module linebuf #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PIX_W = 8
) (
  input  logic             clk,
  input  logic             en,
  input  logic [PIX_W-1:0] din,
  output logic [PIX_W-1:0] dout
);

  logic [PIX_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      mem[0] <= din;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        mem[i] <= mem[i-1];
      end
    end
  end

  assign dout = mem[DEPTH-1];

endmodule

// File: rtl/ifmap_window_gen.sv
// Raster-order pixel stream to sliding 3x3 window generator feeding the
// conv top; one window per accepted pixel once row>=2 and col>=2.
module ifmap_window_gen
  import ifmap_window_gen_pkg::*;
#(
  parameter int unsigned IMG_W = 8,
  parameter int unsigned IMG_H = 8,
  parameter int unsigned PIX_W = PIX_W_DFLT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [PIX_W-1:0]           pix_in,
  input  logic                       pix_valid,
  output logic                       pix_ready,
  output logic [WIN_PIX*PIX_W-1:0]   ifmap_out,
  output logic                       win_valid,
  output logic                       state,
  output logic                       frame_done
);

  localparam int unsigned CW = $clog2(IMG_W);
  localparam int unsigned RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  fsm_state_t fsm_q, fsm_d;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          accept, last_pix, win_fire, first_win;
  logic [PIX_W-1:0] lb1_out, lb2_out;
  logic [PIX_W-1:0] win_q [3][3];
  logic [PIX_W-1:0] win_d [3][3];
  logic [WIN_PIX*PIX_W-1:0] win_packed;

  assign pix_ready = (fsm_q == RUN);
  assign accept    = pix_valid && pix_ready;
  assign last_pix  = (row == ROW_LAST) && (col == COL_LAST);
  assign win_fire  = accept && (row >= ROW_TWO) && (col >= COL_TWO);
  assign first_win = (row == ROW_TWO) && (col == COL_TWO);

  always_ff @(posedge clk) begin
    if (!rst_n) fsm_q <= IDLE;
    else        fsm_q <= fsm_d;
  end

  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      IDLE:    if (start) fsm_d = RUN;
      RUN:     if (accept && last_pix) fsm_d = DONE;
      DONE:    fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (fsm_q == IDLE && start) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Chained: lb1 yields row r-1 at this column, lb2 yields row r-2.
  linebuf #(.DEPTH(IMG_W), .PIX_W(PIX_W)) u_lb1 (
    .clk  (clk),
    .en   (accept),
    .din  (pix_in),
    .dout (lb1_out)
  );

  linebuf #(.DEPTH(IMG_W), .PIX_W(PIX_W)) u_lb2 (
    .clk  (clk),
    .en   (accept),
    .din  (lb1_out),
    .dout (lb2_out)
  );

  always_comb begin
    for (int unsigned r = 0; r < 3; r++) begin
      win_d[r][0] = win_q[r][1];
      win_d[r][1] = win_q[r][2];
    end
    win_d[0][2] = lb2_out;
    win_d[1][2] = lb1_out;
    win_d[2][2] = pix_in;
  end

  always_comb begin
    win_packed = '0;
    for (int unsigned r = 0; r < 3; r++) begin
      for (int unsigned c = 0; c < 3; c++) begin
        win_packed[win_msb(r, c, PIX_W) -: PIX_W] = win_d[r][c];
      end
    end
  end

  // Window registers need no reset: an emitted window only ever holds
  // columns 0..2 or later of the current row, all written this frame.
  always_ff @(posedge clk) begin
    if (accept) win_q <= win_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ifmap_out  <= '0;
      win_valid  <= 1'b0;
      state      <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      win_valid  <= win_fire;
      state      <= win_fire && first_win;
      frame_done <= (fsm_q == DONE);
      if (win_fire) ifmap_out <= win_packed;
    end
  end

endmodule

// File: tb/tb_ifmap_window_gen.sv
// Directed bench for ifmap_window_gen on a 4x4 image: table-driven frames
// plus hand-written gap, mid-frame reset and stray-start sequences.
module tb_ifmap_window_gen;
  import ifmap_window_gen_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n, start, pix_valid;
  logic [7:0]       pix_in;
  logic             pix_ready, win_valid, state, frame_done;
  logic [WIN_W-1:0] ifmap_out;

  always #5 clk = ~clk;

  ifmap_window_gen #(.IMG_W(4), .IMG_H(4), .PIX_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .pix_in     (pix_in),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .ifmap_out  (ifmap_out),
    .win_valid  (win_valid),
    .state      (state),
    .frame_done (frame_done)
  );

  typedef struct {
    logic             start;
    logic             valid;
    logic [7:0]       pix;
    logic             ready;
    logic             wv;
    logic             st;
    logic             done;
    logic [WIN_W-1:0] win;
  } vec_t;

  vec_t             tbl [19];
  logic [WIN_W-1:0] exp_w [4];
  logic [WIN_W-1:0] held;
  int               checks = 0;
  int               errors = 0;
  int               nwin, ndone;

  task automatic check(input string name, input logic [WIN_W-1:0] act,
                       input logic [WIN_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic s, input logic v, input logic [7:0] p);
    start = s; pix_valid = v; pix_in = p;
    @(posedge clk); #1;
    start = 1'b0; pix_valid = 1'b0;
  endtask

  task automatic run_table(input logic [7:0] m);
    for (int i = 0; i < 19; i++) begin
      cyc(tbl[i].start, tbl[i].valid, tbl[i].pix ^ m);
      check("tbl_ready", pix_ready, tbl[i].ready);
      check("tbl_win_valid", win_valid, tbl[i].wv);
      check("tbl_state", state, tbl[i].st);
      check("tbl_frame_done", frame_done, tbl[i].done);
      if (tbl[i].wv) held = tbl[i].win ^ {9{m}};
      check("tbl_ifmap", ifmap_out, held);
    end
  endtask

  task automatic observe(input logic [7:0] m, input logic gap);
    if (gap) check("gap_no_win", win_valid, 1'b0);
    if (win_valid) begin
      if (nwin < 4) begin
        check("seq_win", ifmap_out, exp_w[nwin] ^ {9{m}});
        check("seq_state", state, nwin == 0);
        held = exp_w[nwin] ^ {9{m}};
      end
      nwin++;
    end else begin
      check("seq_hold", ifmap_out, held);
      check("seq_state_low", state, 1'b0);
    end
    if (frame_done) ndone++;
  endtask

  task automatic run_frame(input logic [7:0] m, input logic gaps, input int start_at);
    nwin = 0; ndone = 0;
    cyc(1'b1, 1'b0, 8'h00);
    observe(m, 1'b0);
    for (int k = 0; k < 16; k++) begin
      cyc(k == start_at, 1'b1, 8'(k) ^ m);
      observe(m, 1'b0);
      if (k < 15) check("seq_ready", pix_ready, 1'b1);
      if (gaps) begin
        cyc(1'b0, 1'b0, 8'hEE);
        observe(m, 1'b1);
      end
    end
    for (int i = 0; i < 4 && ndone == 0; i++) begin
      cyc(1'b0, 1'b0, 8'h00);
      observe(m, 1'b0);
    end
    cyc(1'b0, 1'b0, 8'h00);
    observe(m, 1'b0);
    check("seq_nwin", nwin, 4);
    check("seq_ndone", ndone, 1);
  endtask

  initial begin
    exp_w[0] = 72'h000102_040506_08090A;
    exp_w[1] = 72'h010203_050607_090A0B;
    exp_w[2] = 72'h040506_08090A_0C0D0E;
    exp_w[3] = 72'h050607_090A0B_0D0E0F;
    //             start valid pix    ready wv st done window
    tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, '0};
    tbl[1]  = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, '0};
    tbl[2]  = '{1'b0, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0, '0};
    tbl[3]  = '{1'b0, 1'b1, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0, '0};
    tbl[4]  = '{1'b0, 1'b1, 8'h03, 1'b1, 1'b0, 1'b0, 1'b0, '0};
    tbl[5]  = '{1'b0, 1'b1, 8'h04, 1'b1, 1'b0, 1'b0, 1'b0, '0};
    tbl[6]  = '{1'b0, 1'b1, 8'h05, 1'b1, 1'b0, 1'b0, 1'b0, '0};
    tbl[7]  = '{1'b0, 1'b1, 8'h06, 1'b1, 1'b0, 1'b0, 1'b0, '0};
    tbl[8]  = '{1'b0, 1'b1, 8'h07, 1'b1, 1'b0, 1'b0, 1'b0, '0};
    tbl[9]  = '{1'b0, 1'b1, 8'h08, 1'b1, 1'b0, 1'b0, 1'b0, '0};
    tbl[10] = '{1'b0, 1'b1, 8'h09, 1'b1, 1'b0, 1'b0, 1'b0, '0};
    tbl[11] = '{1'b0, 1'b1, 8'h0A, 1'b1, 1'b1, 1'b1, 1'b0, 72'h000102_040506_08090A};
    tbl[12] = '{1'b0, 1'b1, 8'h0B, 1'b1, 1'b1, 1'b0, 1'b0, 72'h010203_050607_090A0B};
    tbl[13] = '{1'b0, 1'b1, 8'h0C, 1'b1, 1'b0, 1'b0, 1'b0, '0};
    tbl[14] = '{1'b0, 1'b1, 8'h0D, 1'b1, 1'b0, 1'b0, 1'b0, '0};
    tbl[15] = '{1'b0, 1'b1, 8'h0E, 1'b1, 1'b1, 1'b0, 1'b0, 72'h040506_08090A_0C0D0E};
    tbl[16] = '{1'b0, 1'b1, 8'h0F, 1'b0, 1'b1, 1'b0, 1'b0, 72'h050607_090A0B_0D0E0F};
    tbl[17] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, '0};
    tbl[18] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, '0};

    rst_n = 1'b0; start = 1'b0; pix_valid = 1'b0; pix_in = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", pix_ready, 1'b0);
    check("rst_win_valid", win_valid, 1'b0);
    check("rst_state", state, 1'b0);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_ifmap", ifmap_out, '0);
    rst_n = 1'b1;
    held = '0;

    // Pixels offered in IDLE are not accepted.
    cyc(1'b0, 1'b1, 8'hFF);
    check("idle_ready", pix_ready, 1'b0);
    check("idle_no_win", win_valid, 1'b0);

    // Two back-to-back frames with different data.
    run_table(8'h00);
    run_table(8'h5A);

    // pix_valid toggling every other cycle.
    run_frame(8'h00, 1'b1, -1);

    // Reset after pixel 0x07, then a clean frame.
    nwin = 0; ndone = 0;
    cyc(1'b1, 1'b0, 8'h00);
    for (int k = 0; k < 8; k++) begin
      cyc(1'b0, 1'b1, 8'(k));
      if (win_valid) nwin++;
    end
    rst_n = 1'b0;
    cyc(1'b0, 1'b1, 8'h08);
    check("midrst_ready", pix_ready, 1'b0);
    check("midrst_win_valid", win_valid, 1'b0);
    check("midrst_ifmap", ifmap_out, '0);
    check("midrst_nwin", nwin, 0);
    rst_n = 1'b1;
    held = '0;
    cyc(1'b0, 1'b1, 8'h09);
    check("postrst_ready", pix_ready, 1'b0);
    check("postrst_no_win", win_valid, 1'b0);
    run_frame(8'h33, 1'b0, -1);

    // Stray start mid-RUN is ignored.
    run_frame(8'hC3, 1'b0, 6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
